// File: rtl/quadrados_dist_pipe.sv
// Pipelined N-channel squared-difference unit: |a_i-b_i| -> table square -> optional sum.
// Define QUADRADOS_SOMA_EN to add a third stage that registers the sum of all channel squares.
module quadrados_dist_pipe #(
  parameter int LARG = 6,
  parameter int N_CH = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              entrada_valida,
  output logic                              entrada_pronta,
  input  logic [N_CH*LARG-1:0]              a,
  input  logic [N_CH*LARG-1:0]              b,
  output logic                              saida_valida,
  input  logic                              saida_pronta,
  output logic [N_CH*2*LARG-1:0]            quadrados,
  output logic [2*LARG+$clog2(N_CH)-1:0]    soma
);

  localparam int W2 = 2 * LARG;
  localparam int LS = W2 + $clog2(N_CH);

  // Square table is pure constant logic; indexing by the absolute difference avoids a multiplier.
  logic [W2-1:0] sq_table [2**LARG];
  for (genvar g = 0; g < 2**LARG; g++) begin : g_table
    assign sq_table[g] = W2'(g * g);
  end

  logic                   v1, v2;
  logic [N_CH*LARG-1:0]   d1, diff;
  logic [N_CH*W2-1:0]     q2, sq;
  logic                   ready1, ready2;

  always_comb begin
    diff = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (a[i*LARG +: LARG] >= b[i*LARG +: LARG])
        diff[i*LARG +: LARG] = a[i*LARG +: LARG] - b[i*LARG +: LARG];
      else
        diff[i*LARG +: LARG] = b[i*LARG +: LARG] - a[i*LARG +: LARG];
    end
  end

  always_comb begin
    sq = '0;
    for (int i = 0; i < N_CH; i++)
      sq[i*W2 +: W2] = sq_table[d1[i*LARG +: LARG]];
  end

  assign ready1         = !v1 || ready2;
  assign entrada_pronta = ready1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else if (ready1) begin
      v1 <= entrada_valida;
      if (entrada_valida) d1 <= diff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2 <= 1'b0;
      q2 <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) q2 <= sq;
    end
  end

`ifdef QUADRADOS_SOMA_EN
  logic                 v3, ready3;
  logic [N_CH*W2-1:0]   q3;
  logic [LS-1:0]        s3, sum2;

  always_comb begin
    sum2 = '0;
    for (int i = 0; i < N_CH; i++)
      sum2 = sum2 + LS'(q2[i*W2 +: W2]);
  end

  assign ready3 = !v3 || saida_pronta;
  assign ready2 = !v2 || ready3;

  // Squares travel alongside the sum so both line up with saida_valida.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3 <= 1'b0;
      q3 <= '0;
      s3 <= '0;
    end else if (ready3) begin
      v3 <= v2;
      if (v2) begin
        q3 <= q2;
        s3 <= sum2;
      end
    end
  end

  assign saida_valida = v3;
  assign quadrados    = q3;
  assign soma         = s3;
`else
  assign ready2       = !v2 || saida_pronta;
  assign saida_valida = v2;
  assign quadrados    = q2;
  assign soma         = {LS{1'b0}};
`endif

endmodule
